// File: rtl/pass_sched_pkg.sv
// Shared types for the layer pass scheduler: FSM states, config field slices
// and the per-layer tile geometry record.
package pass_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ISSUE,
    S_WAIT,
    S_ADV,
    S_DONE
  } state_t;

  localparam int unsigned MP_T_LSB    = 0;
  localparam int unsigned MP_R_LSB    = 3;
  localparam int unsigned MP_Q_LSB    = 6;
  localparam int unsigned MP_P_LSB    = 9;
  localparam int unsigned MP_FIELD_W  = 3;

  localparam int unsigned SP1_S_LSB   = 20;
  localparam int unsigned SP1_R_LSB   = 22;
  localparam int unsigned SP1_FIELD_W = 2;

  // Tile counts are carried wide enough for any CNT_W up to 16.
  localparam int unsigned GEOM_N_W    = 17;

  typedef struct packed {
    logic [5:0]          pt;
    logic [5:0]          qr;
    logic [15:0]         fb;
    logic [16:0]         rs;
    logic [GEOM_N_W-1:0] n_oc;
    logic [GEOM_N_W-1:0] n_ic;
  } tile_geom_t;

endpackage

// File: rtl/tile_geom_calc.sv
// Combinational tile geometry for one layer: tile sizes, per-tile filter/record
// byte sizes and output/input channel tile counts.
module tile_geom_calc
  import pass_sched_pkg::*;
#(
  parameter int unsigned CNT_W = 10
) (
  input  logic [CNT_W-1:0] m,
  input  logic [CNT_W-1:0] c,
  input  logic [2:0]       p,
  input  logic [2:0]       q,
  input  logic [2:0]       r,
  input  logic [2:0]       t,
  input  logic [1:0]       kr,
  input  logic [1:0]       ks,
  output tile_geom_t       geom
);

  localparam int unsigned NW = CNT_W + 1;

  logic [5:0]    pt;
  logic [5:0]    qr;
  logic [15:0]   fb;
  logic [NW-1:0] pt_div;
  logic [NW-1:0] qr_div;
  logic [NW-1:0] n_oc_w;
  logic [NW-1:0] n_ic_w;

  always_comb begin
    pt = 6'(p) * 6'(t);
    qr = 6'(q) * 6'(r);
    fb = 16'(pt) * 16'(qr) * 16'(kr) * 16'(ks);
    // Zero tile sizes are flagged as config errors upstream; divide by 1 keeps this defined.
    pt_div = (pt == '0) ? NW'(1) : NW'(pt);
    qr_div = (qr == '0) ? NW'(1) : NW'(qr);
    n_oc_w = (NW'(m) + pt_div - NW'(1)) / pt_div;
    n_ic_w = (NW'(c) + qr_div - NW'(1)) / qr_div;

    geom      = '0;
    geom.pt   = pt;
    geom.qr   = qr;
    geom.fb   = fb;
    geom.rs   = 17'(fb) + 17'({pt, 2'b00});
    geom.n_oc = GEOM_N_W'(n_oc_w);
    geom.n_ic = GEOM_N_W'(n_ic_w);
  end

endmodule

// File: rtl/layer_pass_scheduler.sv
// Layer-level sequencer: tiles a layer into (oc, ic) passes and drives the pass controller.
// Optional wait-cycle performance counter enabled by `define PASS_PERF_CNT_EN.
module layer_pass_scheduler
  import pass_sched_pkg::*;
#(
  parameter int unsigned CNT_W  = 10,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  layer_M,
  input  logic [CNT_W-1:0]  layer_C,
  input  logic [31:0]       op_config_in,
  input  logic [31:0]       mapping_param_in,
  input  logic [31:0]       shape_param1_in,
  input  logic [31:0]       shape_param2_in,
  input  logic [ADDR_W-1:0] filter_base,
  input  logic [ADDR_W-1:0] ifmap_base,
  input  logic [ADDR_W-1:0] ifmap_tile_stride,
  input  logic [ADDR_W-1:0] opsum_base,
  input  logic [ADDR_W-1:0] opsum_tile_stride,
  output logic [31:0]       pass_op_config,
  output logic [31:0]       pass_mapping_param,
  output logic [31:0]       pass_shape_param1,
  output logic [31:0]       pass_shape_param2,
  output logic              pass_bias_ipsum_sel,
  output logic [ADDR_W-1:0] pass_filter_baseaddr,
  output logic [ADDR_W-1:0] pass_ifmap_baseaddr,
  output logic [ADDR_W-1:0] pass_bias_baseaddr,
  output logic [ADDR_W-1:0] pass_opsum_baseaddr,
  input  logic              pass_done,
  output logic              busy,
  output logic              layer_done,
  output logic              cfg_err,
  output logic [31:0]       perf_wait_cycles
);

  state_t state, state_nxt;

  logic [CNT_W-1:0]    m_q, c_q, oc, ic;
  logic [31:1]         opcfg_q;
  logic [31:0]         map_q, sh1_q, sh2_q;
  logic [ADDR_W-1:0]   fbase_q, ibase_q, istride_q, obase_q, ostride_q;
  logic [ADDR_W-1:0]   fptr, iptr, optr;
  logic [15:0]         fb_q;
  logic [16:0]         rs_q;
  logic [GEOM_N_W-1:0] n_oc_q, n_ic_q;
  logic                cfg_err_q;
  logic                start_bit;
  logic                cfg_bad;
  logic                last_ic, last_oc;
  tile_geom_t          geom;

  tile_geom_calc #(.CNT_W(CNT_W)) u_geom (
    .m    (m_q),
    .c    (c_q),
    .p    (map_q[MP_P_LSB +: MP_FIELD_W]),
    .q    (map_q[MP_Q_LSB +: MP_FIELD_W]),
    .r    (map_q[MP_R_LSB +: MP_FIELD_W]),
    .t    (map_q[MP_T_LSB +: MP_FIELD_W]),
    .kr   (sh1_q[SP1_R_LSB +: SP1_FIELD_W]),
    .ks   (sh1_q[SP1_S_LSB +: SP1_FIELD_W]),
    .geom (geom)
  );

  // pt == 0 iff p or t is 0, likewise qr for q and r.
  assign cfg_bad = (m_q == '0) || (c_q == '0) || (geom.pt == '0) || (geom.qr == '0) ||
                   (sh1_q[SP1_R_LSB +: SP1_FIELD_W] == '0) ||
                   (sh1_q[SP1_S_LSB +: SP1_FIELD_W] == '0);

  assign last_ic = (GEOM_N_W'(ic) + GEOM_N_W'(1)) == n_ic_q;
  assign last_oc = (GEOM_N_W'(oc) + GEOM_N_W'(1)) == n_oc_q;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_CALC;
      S_CALC:  state_nxt = cfg_bad ? S_DONE : S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (pass_done) state_nxt = S_ADV;
      S_ADV:   state_nxt = (last_ic && last_oc) ? S_DONE : S_ISSUE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != S_IDLE);
    layer_done = (state == S_DONE);
    start_bit  = (state == S_ISSUE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q       <= '0;
      c_q       <= '0;
      opcfg_q   <= '0;
      map_q     <= '0;
      sh1_q     <= '0;
      sh2_q     <= '0;
      fbase_q   <= '0;
      ibase_q   <= '0;
      istride_q <= '0;
      obase_q   <= '0;
      ostride_q <= '0;
      fptr      <= '0;
      iptr      <= '0;
      optr      <= '0;
      oc        <= '0;
      ic        <= '0;
      fb_q      <= '0;
      rs_q      <= '0;
      n_oc_q    <= '0;
      n_ic_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (start) begin
          m_q       <= layer_M;
          c_q       <= layer_C;
          opcfg_q   <= op_config_in[31:1];
          map_q     <= mapping_param_in;
          sh1_q     <= shape_param1_in;
          sh2_q     <= shape_param2_in;
          fbase_q   <= filter_base;
          ibase_q   <= ifmap_base;
          istride_q <= ifmap_tile_stride;
          obase_q   <= opsum_base;
          ostride_q <= opsum_tile_stride;
          cfg_err_q <= 1'b0;
        end
        S_CALC: begin
          fb_q   <= geom.fb;
          rs_q   <= geom.rs;
          n_oc_q <= geom.n_oc;
          n_ic_q <= geom.n_ic;
          if (cfg_bad) begin
            cfg_err_q <= 1'b1;
          end else begin
            oc   <= '0;
            ic   <= '0;
            fptr <= fbase_q;
            iptr <= ibase_q;
            optr <= obase_q;
          end
        end
        S_ADV: begin
          fptr <= fptr + ADDR_W'(rs_q);
          if (last_ic) begin
            ic   <= '0;
            iptr <= ibase_q;
            if (!last_oc) begin
              oc   <= oc + CNT_W'(1);
              optr <= optr + ostride_q;
            end
          end else begin
            ic   <= ic + CNT_W'(1);
            iptr <= iptr + istride_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Pointers only move on the ADV->ISSUE edge, so the pass outputs are stable through WAIT.
  assign pass_op_config       = {opcfg_q, start_bit};
  assign pass_mapping_param   = map_q;
  assign pass_shape_param1    = sh1_q;
  assign pass_shape_param2    = sh2_q;
  assign pass_bias_ipsum_sel  = busy && (ic == '0);
  assign pass_filter_baseaddr = fptr;
  assign pass_bias_baseaddr   = fptr + ADDR_W'(fb_q);
  assign pass_ifmap_baseaddr  = iptr;
  assign pass_opsum_baseaddr  = optr;
  assign cfg_err              = cfg_err_q;

`ifdef PASS_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (rst)                                 perf_q <= '0;
    else if (state == S_IDLE && start)       perf_q <= '0;
    else if (state == S_WAIT && perf_q != '1) perf_q <= perf_q + 32'd1;
  end

  assign perf_wait_cycles = perf_q;
`else
  assign perf_wait_cycles = '0;
`endif

endmodule
